adc_seq_ctrl: RTL

// Responder side of the ADC step in the CIM timestep loop. Accepts a one-cycle adc_kick_pulse and steps
// the bitline mux through all NUM_OUTPUTS columns. For each column it waits for settling, fires one ADC

---
 rtl/adc_seq_ctrl_if.sv | 26 ++
 rtl/adc_seq_ctrl.sv | 98 +++++++++
 2 files changed

// File: rtl/adc_seq_ctrl_if.sv
// adc_seq_ctrl_if: kick/abort controls, ADC sample/data handshake and frame outputs of the ADC sequencer.
interface adc_seq_ctrl_if #(
    parameter int NUM_OUTPUTS = 10,
    parameter int ADC_BITS    = 8
);
    localparam int SEL_W = $clog2(NUM_OUTPUTS);
    logic                            soft_reset_pulse;
    logic                            adc_kick_pulse;
    logic [SEL_W-1:0]                bl_sel;
    logic                            adc_sample;
    logic                            adc_data_valid;
    logic [ADC_BITS-1:0]             adc_data;
    logic                            neuron_in_valid;
    logic [NUM_OUTPUTS*ADC_BITS-1:0] neuron_in_data;
    logic                            busy;
    logic                            overrun_err;
    logic                            timeout_err;
    modport slave (
        input  soft_reset_pulse, adc_kick_pulse, adc_data_valid, adc_data,
        output bl_sel, adc_sample, neuron_in_valid, neuron_in_data, busy, overrun_err, timeout_err
    );
    modport master (
        output soft_reset_pulse, adc_kick_pulse, adc_data_valid, adc_data,
        input  bl_sel, adc_sample, neuron_in_valid, neuron_in_data, busy, overrun_err, timeout_err
    );
endinterface

// File: rtl/adc_seq_ctrl.sv
// adc_seq_ctrl: steps the bitline mux over all columns, samples each through the shared ADC
// and emits one packed frame per kick, with overrun and per-column timeout detection.
module adc_seq_ctrl #(
    parameter int NUM_OUTPUTS    = 10,
    parameter int ADC_BITS       = 8,
    parameter int SETTLE_CYCLES  = 3,
    parameter int TIMEOUT_CYCLES = 16
) (
    input logic         clk,
    input logic         rst_n,
    adc_seq_ctrl_if.slave bus
);
    localparam int SEL_W = $clog2(NUM_OUTPUTS);
    localparam int SC_W  = $clog2(SETTLE_CYCLES + 1);
    localparam int WC_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [SEL_W-1:0] COL_LAST    = SEL_W'(NUM_OUTPUTS - 1);
    localparam logic [SC_W-1:0]  SETTLE_LAST = SC_W'(SETTLE_CYCLES - 1);
    localparam logic [WC_W-1:0]  WAIT_LAST   = WC_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, SETTLE, WAIT, DONE} state_t;

    state_t                          state;
    logic [SC_W-1:0]                 settle_cnt;
    logic [WC_W-1:0]                 wait_cnt;
    logic [NUM_OUTPUTS*ADC_BITS-1:0] shadow;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state               <= IDLE;
            settle_cnt          <= '0;
            wait_cnt            <= '0;
            shadow              <= '0;
            bus.bl_sel          <= '0;
            bus.adc_sample      <= 1'b0;
            bus.neuron_in_valid <= 1'b0;
            bus.neuron_in_data  <= '0;
            bus.busy            <= 1'b0;
            bus.overrun_err     <= 1'b0;
            bus.timeout_err     <= 1'b0;
        end else begin
            bus.adc_sample      <= 1'b0;
            bus.neuron_in_valid <= 1'b0;
            if (bus.soft_reset_pulse) begin
                state              <= IDLE;
                settle_cnt         <= '0;
                wait_cnt           <= '0;
                shadow             <= '0;
                bus.bl_sel         <= '0;
                bus.neuron_in_data <= '0;
                bus.busy           <= 1'b0;
                bus.overrun_err    <= 1'b0;
                bus.timeout_err    <= 1'b0;
            end else begin
                if (bus.adc_kick_pulse && state != IDLE)
                    bus.overrun_err <= 1'b1;
                case (state)
                    IDLE: if (bus.adc_kick_pulse) begin
                        bus.bl_sel <= '0;
                        settle_cnt <= '0;
                        bus.busy   <= 1'b1;
                        state      <= SETTLE;
                    end
                    SETTLE: begin
                        settle_cnt <= settle_cnt + 1'b1;
                        if (settle_cnt == SETTLE_LAST) begin
                            bus.adc_sample <= 1'b1;
                            wait_cnt       <= '0;
                            state          <= WAIT;
                        end
                    end
                    WAIT: begin
                        // A valid arriving in the expiring cycle still counts as an answer.
                        if (bus.adc_data_valid || wait_cnt == WAIT_LAST) begin
                            shadow[int'(bus.bl_sel)*ADC_BITS +: ADC_BITS] <= bus.adc_data_valid ? bus.adc_data : '0;
                            if (!bus.adc_data_valid)
                                bus.timeout_err <= 1'b1;
                            if (bus.bl_sel == COL_LAST)
                                state <= DONE;
                            else begin
                                bus.bl_sel <= bus.bl_sel + 1'b1;
                                settle_cnt <= '0;
                                state      <= SETTLE;
                            end
                        end else
                            wait_cnt <= wait_cnt + 1'b1;
                    end
                    DONE: begin
                        bus.neuron_in_data  <= shadow;
                        bus.busy            <= 1'b0;
                        bus.neuron_in_valid <= 1'b1;
                        state               <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule
